// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: shared state encoding and default sizing for the display scanner
package seg7_scan_pkg;
    typedef enum logic {ST_BLANK, ST_SHOW} state_t;
    localparam int NUM_DIGITS_DEF   = 4;
    localparam int SCAN_DIV_DEF     = 10000;
    localparam int BLANK_CYCLES_DEF = 16;
endpackage

// File: rtl/seg7.sv
// seg7: hex nibble to gfedcba segment pattern, active-high
module seg7 (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    // pure lookup, one pattern per nibble value
    always_comb begin
        seg = 7'h00;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed scan of NUM_DIGITS digits with blanking gap and frame-aligned double buffer
module seg7_scan_ctrl
    import seg7_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int SCAN_DIV     = SCAN_DIV_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_blank,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_start
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           cnt, cnt_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    state_t                  st, st_nxt;
    logic                    run;
    logic [4*NUM_DIGITS-1:0] act_data, pend_data;
    logic [NUM_DIGITS-1:0]   act_blank, pend_blank;
    logic                    pend_full;
    logic                    slot_end, frame_end, show;
    logic [3:0]              nib;
    logic [6:0]              seg_dec;

    assign wr_ready = !pend_full;

    // next slot position and phase; the first cycle out of reset holds at frame start
    always_comb begin
        slot_end  = cnt == CW'(SCAN_DIV - 1);
        frame_end = slot_end && idx == IW'(NUM_DIGITS - 1);
        cnt_nxt   = (!run || slot_end) ? '0 : cnt + 1'b1;
        idx_nxt   = (!run || frame_end) ? '0 : slot_end ? idx + 1'b1 : idx;
        st_nxt    = !run ? ST_BLANK
                  : (st == ST_BLANK && cnt == CW'(BLANK_CYCLES - 1)) ? ST_SHOW
                  : (st == ST_SHOW && slot_end) ? ST_BLANK : st;
        nib       = act_data[{idx_nxt, 2'b00} +: 4];
        show      = st_nxt == ST_SHOW && !act_blank[idx_nxt];
    end

    seg7 u_seg7 (
        .hex (nib),
        .seg (seg_dec)
    );

    // scan position and phase registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
            idx <= '0;
            st  <= ST_BLANK;
        end else begin
            run <= 1'b1;
            cnt <= cnt_nxt;
            idx <= idx_nxt;
            st  <= st_nxt;
        end
    end

    // pending buffer accepts writes; it moves to active only on the frame boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_data   <= '0;
            act_blank  <= '1;
            pend_data  <= '0;
            pend_blank <= '1;
            pend_full  <= 1'b0;
        end else begin
            if (frame_end && pend_full) begin
                act_data  <= pend_data;
                act_blank <= pend_blank;
                pend_full <= 1'b0;
            end
            if (wr_valid && !pend_full) begin
                pend_data  <= wr_data;
                pend_blank <= wr_blank;
                pend_full  <= 1'b1;
            end
        end
    end

    // outputs registered from next position so they line up with cnt/idx of the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig_en      <= '0;
            seg_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            dig_en      <= show ? NUM_DIGITS'(1) << idx_nxt : '0;
            seg_out     <= show ? seg_dec : '0;
            frame_start <= cnt_nxt == '0 && idx_nxt == '0;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed and random stimulus checked against a cycle-count display model
module tb_seg7_scan_ctrl;
    localparam int N  = 4;
    localparam int SD = 8;
    localparam int B  = 2;
    localparam int FP = N * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_blank = '0;
    logic [6:0]  seg_out;
    logic [3:0]  dig_en;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int t = -1;
    logic [15:0] m_act = '0, m_pend = '0;
    logic [3:0]  m_ablank = '1, m_pblank = '1;
    logic        m_pfull = 1'b0;
    logic [6:0]  segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(B)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_blank    (wr_blank),
        .seg_out     (seg_out),
        .dig_en      (dig_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
        end
    endtask

    // expected outputs follow directly from elapsed cycles since reset and the model buffers
    task automatic check_all();
        int c, d;
        logic [3:0] e_dig;
        logic [6:0] e_seg;
        logic e_fs;
        e_dig = '0;
        e_seg = '0;
        e_fs  = 1'b0;
        if (t >= 0) begin
            c    = t % SD;
            d    = (t / SD) % N;
            e_fs = (t % FP) == 0;
            if (c >= B && !m_ablank[d]) begin
                e_dig = 4'(1 << d);
                e_seg = segtab[m_act[d*4 +: 4]];
            end
        end
        chk("dig_en", 32'(dig_en), 32'(e_dig));
        chk("seg_out", 32'(seg_out), 32'(e_seg));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("wr_ready", 32'(wr_ready), 32'(!m_pfull));
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic [3:0] b, input logic r);
        logic acc;
        wr_valid = v;
        wr_data  = d;
        wr_blank = b;
        rst_n    = r;
        @(posedge clk);
        if (!r) begin
            t = -1;
            m_act = '0;
            m_ablank = '1;
            m_pend = '0;
            m_pblank = '1;
            m_pfull = 1'b0;
        end else begin
            acc = v && !m_pfull;
            if (t % FP == FP - 1 && m_pfull) begin
                m_act = m_pend;
                m_ablank = m_pblank;
                m_pfull = 1'b0;
            end
            if (acc) begin
                m_pend = d;
                m_pblank = b;
                m_pfull = 1'b1;
            end
            t++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 16'($urandom), 4'($urandom), 1'b1);
    endtask

    task automatic wait_phase(input int p);
        int k = 0;
        while (t % FP != p && k < 2 * FP) begin
            idle();
            k++;
        end
        chk("wait_phase_timeout", 32'(k < 2 * FP), 32'd1);
    endtask

    initial begin
        int k;
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        chk("first_frame_start", 32'(frame_start), 32'd1);
        repeat (63) idle();

        step(1'b1, 16'h1234, 4'b0000, 1'b1);
        chk("ready_low_after_write", 32'(wr_ready), 32'd0);
        wait_phase(FP - 1);
        idle();
        wait_phase(2);
        chk("d0_en", 32'(dig_en), 32'h1);
        chk("d0_seg4", 32'(seg_out), 32'h66);
        wait_phase(26);
        chk("d3_en", 32'(dig_en), 32'h8);
        chk("d3_seg1", 32'(seg_out), 32'h06);
        chk("ready_back", 32'(wr_ready), 32'd1);

        step(1'b1, 16'hAAAA, 4'b0000, 1'b1);
        k = 0;
        while (!(m_pfull && m_pend == 16'hFEDC) && k < 3 * FP) begin
            step(1'b1, 16'hFEDC, 4'b0000, 1'b1);
            k++;
        end
        chk("second_write_accepted", 32'(k < 3 * FP), 32'd1);
        wait_phase(26);
        chk("frame_a_seg", 32'(seg_out), 32'h77);
        wait_phase(FP - 1);
        idle();
        wait_phase(26);
        chk("frame_f_seg", 32'(seg_out), 32'h71);

        step(1'b1, 16'h5555, 4'b0100, 1'b1);
        wait_phase(FP - 1);
        idle();
        wait_phase(20);
        chk("blank_d2_en", 32'(dig_en), 32'h0);
        chk("blank_d2_seg", 32'(seg_out), 32'h0);
        wait_phase(10);
        chk("d1_seg5", 32'(seg_out), 32'h6D);

        wait_phase(20);
        step(1'b0, '0, '0, 1'b0);
        chk("reset_dark", 32'(dig_en), 32'h0);
        chk("reset_ready", 32'(wr_ready), 32'd1);
        repeat (70) idle();

        wait_phase(FP - 1);
        step(1'b1, 16'h9876, 4'b0000, 1'b1);
        wait_phase(26);
        chk("boundary_write_not_yet", 32'(dig_en), 32'h0);
        wait_phase(FP - 1);
        idle();
        wait_phase(26);
        chk("boundary_write_shown", 32'(seg_out), 32'h6F);

        repeat (1000)
            step($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom), $urandom_range(0, 299) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a multi-digit 7-segment display. It shares one `seg7` hex decoder among `NUM_DIGITS` digit positions. It cycles one-hot digit enables with a fixed dwell time and a blanking gap between digits to prevent ghosting. It sits between counter/datapath logic, which supplies hex nibbles through a valid/ready write port, and the chip's output pins (`uo_out` segments, `uio_out` digit enables).

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of digit positions. Legal range 1..8.
- `SCAN_DIV`, default 10000: clock cycles per digit slot (dwell). Must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 16: cycles at the start of each slot during which no digit is enabled. Must be at least 1.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  pending buffer empty; the write is accepted on `wr_valid && wr_ready`
- `wr_data`  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i
- `wr_blank`  in  NUM_DIGITS  per-digit blank mask; 1 = digit dark
- `seg_out`  out  7  segment pattern (gfedcba, `seg7` encoding), registered
- `dig_en`  out  NUM_DIGITS  one-hot digit enable, active-high, registered
- `frame_start`  out  1  one-cycle pulse at the start of each frame (digit 0, slot count 0), registered

## Operation
- Slot counter `cnt` runs 0..SCAN_DIV-1. When it wraps, digit index `idx` advances 0..NUM_DIGITS-1 and wraps back to 0.
- FSM states:
  - BLANK while `cnt < BLANK_CYCLES`.
  - SHOW while `cnt >= BLANK_CYCLES`.
  - BLANK→SHOW when `cnt == BLANK_CYCLES-1`.
  - SHOW→BLANK when `cnt == SCAN_DIV-1`; `idx` increments at the same time.
- In SHOW with `active_blank[idx]==0`:
  - `dig_en` = one-hot(idx).
  - `seg_out` = seg7(active_data nibble idx).
- Otherwise `dig_en` = 0 and `seg_out` = 0.
- Double buffering uses a pending register (data, blank) plus a `pend_full` flag.
  - `wr_ready = !pend_full`.
  - An accepted write loads pending and sets `pend_full`.
- Frame boundary is the cycle where `cnt==SCAN_DIV-1` and `idx==NUM_DIGITS-1`.
  - If `pend_full`, pending is copied to active and `pend_full` clears.
  - The display therefore never changes mid-frame.
- Simultaneous write and boundary: impossible while `pend_full` (ready is low). If pending is empty at the boundary, a write accepted in that cycle is applied at the following boundary.
- Width rules:
  - `cnt` is $clog2(SCAN_DIV) bits.
  - `idx` is $clog2(NUM_DIGITS) bits, minimum 1.
  - Both wrap explicitly by compare, never by overflow.

## Timing
- Reset values:
  - `cnt`=0, `idx`=0, state BLANK.
  - `active_data`=0, `active_blank`=all 1s.
  - `pend_full`=0, so `wr_ready`=1.
  - `dig_en`=0, `seg_out`=0, `frame_start`=0.
- Outputs are registered from next-state logic. The output value in a cycle corresponds exactly to that cycle's `cnt` and `idx`, with no extra lag.
- Digit i is lit for cycles BLANK_CYCLES..SCAN_DIV-1 of its slot. Frame period = NUM_DIGITS*SCAN_DIV cycles.
- `frame_start`=1 in every cycle with `cnt==0` and `idx==0`, except the cycle reset is asserted. The first pulse is in the first cycle after reset deasserts.
- Write-to-display latency: from the accept cycle to the first frame_start after the next boundary. Worst case is about one frame plus one cycle.
- `wr_ready` falls the cycle after an accept. It rises the cycle after the boundary transfer.
- Reset mid-operation aborts the slot and discards pending and active contents. The display is dark until a new write reaches a boundary.

## Structure
- Package `seg7_scan_pkg`:
  - FSM state enum (ST_BLANK, ST_SHOW).
  - Default parameter constants (`SCAN_DIV_DEF`, `BLANK_CYCLES_DEF`, `NUM_DIGITS_DEF`).
- One sub-module: the existing `seg7` hex decoder, instantiated once. It is fed by the nibble mux selected by `idx`, and its output is registered into `seg_out` in this block.
- Top-level wrapper mapping:
  - `seg_out` → `uo_out[6:0]`.
  - `dig_en` → `uio_out[NUM_DIGITS-1:0]`, with `uio_oe` set to those bits.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
- Reset, no writes, run 64 cycles → `dig_en`=0 and `seg_out`=0 throughout; `wr_ready`=1; `frame_start` pulses every 32 cycles, first in cycle 0 after reset.
- Write `wr_data`=16'h1234, `wr_blank`=0 → `wr_ready`=0 next cycle. After the boundary:
  - digit-0 slot: `dig_en`=4'b0001 at `cnt` 2..7 with seg7(4);
  - digit 3 shows seg7(1);
  - `wr_ready` returns to 1.
- Two back-to-back writes, 16'hAAAA then 16'hFEDC → second write stalls (`wr_ready`=0) until the first boundary, is accepted after, and shows F on digit 3 one frame later.
- `wr_blank`=4'b0100 with 16'h5555 → `dig_en` never equals 4'b0100; `seg_out`=0 during all of slot 2; other digits show seg7(5).
- Assert reset during the SHOW phase of digit 2 after a valid display → next cycle `dig_en`=0, `wr_ready`=1, and the display stays dark until a new write reaches a boundary.
- Write accepted exactly in the boundary cycle, with pending empty → it is not applied at that boundary; it appears one frame later.
